// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Instruction-fetch controller between instruction memory and decode.
//   Owns the PC, presents it as a byte address to a combinational-read
//   memory, captures each fetched word with its PC into a small FIFO and
//   hands the head entry to decode over a valid/ready handshake.
//   Stops on HALT_WORD, raises an exception on a misaligned or
//   out-of-range fetch, and supports branch redirect with buffer flush.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   start        one-cycle pulse, leaves IDLE
//   imem_addr    byte address to instruction memory (== pc)
//   imem_data    combinational read data for imem_addr
//   inst         buffer head instruction (holds last value when empty)
//   inst_pc      byte address of inst
//   inst_valid   buffer non-empty
//   inst_ready   decode accepts the head entry this cycle
//   redirect     branch taken: flush and refetch from redirect_pc
//   redirect_pc  redirect target (byte address)
//   halted       halt word reached and buffer drained
//   exc          bad fetch address reached and buffer drained
//   exc_pc       offending fetch address
//
// Optional build macro FETCH_PERF_EN adds saturating 16-bit counters
//   fetch_cnt    pushes into the buffer
//   stall_cnt    RUN cycles with a good address but no buffer space

module fetch_sequencer #(
    parameter int unsigned            ADDR_WIDTH = 16,
    parameter int unsigned            DATA_WIDTH = 16,
    parameter int unsigned            MEM_SIZE   = 26,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0,
    parameter logic [DATA_WIDTH-1:0]  HALT_WORD  = 16'hEFFF,
    parameter int unsigned            BUF_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_data,
    output logic [DATA_WIDTH-1:0] inst,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  halted,
    output logic                  exc,
    output logic [ADDR_WIDTH-1:0] exc_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]           fetch_cnt,
    output logic [15:0]           stall_cnt
`endif
);

    localparam int unsigned         PTR_W     = $clog2(BUF_DEPTH);
    localparam logic [PTR_W:0]      DEPTH     = (PTR_W+1)'(BUF_DEPTH);
    localparam logic [PTR_W:0]      ONE_ENTRY = (PTR_W+1)'(1);
    localparam logic [ADDR_WIDTH:0] MEM_WORDS = (ADDR_WIDTH+1)'(MEM_SIZE);

    typedef enum logic [2:0] {
        IDLE, RUN, DRAIN_HALT, DRAIN_EXC, HALT, EXC
    } state_t;

    state_t state, next_state;

    logic [DATA_WIDTH-1:0] buf_data [BUF_DEPTH];
    logic [ADDR_WIDTH-1:0] buf_pc   [BUF_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [PTR_W:0]        count;
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] hold_inst;
    logic [ADDR_WIDTH-1:0] hold_pc;

    logic in_run, draining, flush, accept, pop, space, bad, halt_hit;
    logic push, capture_exc, drained;

    // Fetch/handshake decode shared by next-state and datapath
    always_comb begin
        in_run      = (state == RUN);
        draining    = (state == DRAIN_HALT) || (state == DRAIN_EXC);
        flush       = redirect && (in_run || draining);
        accept      = inst_valid && inst_ready;
        // a redirect discards the same-cycle pop along with everything else
        pop         = accept && !flush;
        space       = (count < DEPTH) || accept;
        bad         = pc[0] || ({1'b0, pc >> 1} >= MEM_WORDS);
        halt_hit    = (imem_data == HALT_WORD);
        push        = in_run && !flush && !bad && space && !halt_hit;
        capture_exc = in_run && !flush && bad;
        drained     = (count == '0) || ((count == ONE_ENTRY) && pop);
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start) next_state = RUN;
            RUN: begin
                if (flush)                 next_state = RUN;
                else if (bad)              next_state = DRAIN_EXC;
                else if (space && halt_hit) next_state = DRAIN_HALT;
            end
            DRAIN_HALT: begin
                if (flush)        next_state = RUN;
                else if (drained) next_state = HALT;
            end
            DRAIN_EXC: begin
                if (flush)        next_state = RUN;
                else if (drained) next_state = EXC;
            end
            HALT:    next_state = HALT;
            EXC:     next_state = EXC;
            default: next_state = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        imem_addr  = pc;
        inst_valid = (count != '0);
        inst       = inst_valid ? buf_data[rd_ptr] : hold_inst;
        inst_pc    = inst_valid ? buf_pc[rd_ptr]   : hold_pc;
        halted     = (state == HALT);
        exc        = (state == EXC);
    end

    // Buffer storage needs no reset: inst_valid qualifies every read
    always_ff @(posedge clk) begin
        if (push) begin
            buf_data[wr_ptr] <= imem_data;
            buf_pc[wr_ptr]   <= pc;
        end
    end

    // PC, buffer pointers, exception address, held head
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc        <= RESET_PC;
            exc_pc    <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            hold_inst <= '0;
            hold_pc   <= '0;
        end else begin
            // track the visible head so inst/inst_pc freeze once empty
            if (inst_valid) begin
                hold_inst <= buf_data[rd_ptr];
                hold_pc   <= buf_pc[rd_ptr];
            end
            if (flush || (state == IDLE && redirect)) pc <= redirect_pc;
            else if (push)                            pc <= pc + ADDR_WIDTH'(2);
            if (capture_exc) exc_pc <= pc;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic stall;

    always_comb stall = in_run && !space && !bad;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (push && fetch_cnt != '1)  fetch_cnt <= fetch_cnt + 1'b1;
            if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
        end
    end
`else
    // counters not built
`endif

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch controller sitting between the instruction memory and the decode stage.
- Owns the PC and drives the memory's byte address; memory read data is combinational.
- Each fetched word is captured, together with its PC, into a small prefetch buffer, and handed to decode over a valid/ready handshake.
- Handles branch redirect/flush, stops on the halt word, and flags fetches outside the populated memory.

Parameters:
- ADDR_WIDTH, 16, PC/memory address width (byte address).
- DATA_WIDTH, 16, instruction width.
- MEM_SIZE, 26, number of populated instruction words; valid byte addresses are 0..2*MEM_SIZE-2.
- RESET_PC, 0, PC value after reset.
- HALT_WORD, 16'hEFFF, instruction encoding that ends fetch.
- BUF_DEPTH, 2, prefetch buffer entries (power of two, >=2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins fetch from IDLE.
- imem_addr  out  ADDR_WIDTH  byte address to instruction memory; equals pc.
- imem_data  in  DATA_WIDTH  combinational read data for imem_addr.
- inst  out  DATA_WIDTH  buffer head instruction.
- inst_pc  out  ADDR_WIDTH  byte address of inst.
- inst_valid  out  1  buffer non-empty.
- inst_ready  in  1  decode accepts the head entry this cycle.
- redirect  in  1  branch taken; flush and refetch.
- redirect_pc  in  ADDR_WIDTH  redirect target (byte address).
- halted  out  1  halt word reached and buffer drained.
- exc  out  1  bad fetch address reached and buffer drained.
- exc_pc  out  ADDR_WIDTH  offending address.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, pc=RESET_PC, buffer empty.
  - inst_valid=0, inst=0, inst_pc=0, halted=0, exc=0, exc_pc=0.
- States: IDLE, RUN, DRAIN_HALT, DRAIN_EXC, HALT, EXC.
- IDLE:
  - No fetch.
  - start=1 -> RUN next cycle.
  - redirect loads pc=redirect_pc and stays IDLE.
- RUN, every cycle:
  - pop = inst_valid & inst_ready.
  - space = (count<BUF_DEPTH) | pop.
  - bad = pc[0] | (pc>>1 >= MEM_SIZE).
  - If bad: no push; exc_pc<=pc; go to DRAIN_EXC.
  - Else if space & imem_data==HALT_WORD: no push; pc holds; go to DRAIN_HALT.
  - Else if space: push {imem_data, pc}; pc<=pc+2, wrapping modulo 2^ADDR_WIDTH.
  - Else: stall; pc holds.
- Latency: a word fetched at edge N is visible on inst at N+1 if the buffer was empty (1-cycle fetch-to-decode latency).
- Buffer: FIFO ordering. Push and pop in the same cycle are allowed when full; count is unchanged.
- DRAIN_HALT / DRAIN_EXC:
  - Decode continues to pop.
  - When count reaches 0 (including the cycle the last entry is popped), go to HALT/EXC.
- HALT: halted=1 and holds. Only reset leaves HALT; start and redirect are ignored.
- EXC: exc=1 and holds; exc_pc is stable. Only reset leaves EXC.
- Redirect (RUN, DRAIN_HALT, DRAIN_EXC):
  - Highest priority; the same-cycle pop, push, halt detection and bad-address detection are discarded.
  - Buffer is flushed; pc<=redirect_pc; state<=RUN.
  - inst_valid=0 in the following cycle.
  - A pending exc_pc capture is cancelled; exc_pc retains its prior value.
- inst/inst_pc hold their last value when the buffer is empty; only inst_valid qualifies them.
- Reset mid-operation: immediate return to the reset values above, regardless of state or buffer contents.

Optional Feature:
- Macro: FETCH_PERF_EN.
- When defined, adds two outputs:
  - fetch_cnt [15:0]: increments on each push.
  - stall_cnt [15:0]: increments on each RUN cycle where space=0 and not bad.
  - Both cleared by reset, saturate at 16'hFFFF, and are unaffected by redirect.
- When not defined: the ports and logic are absent and the behaviour is otherwise identical.

Test Plan:
- Streaming: memory preloaded with the 26-word program (word 25 = 16'hEFFF), inst_ready=1, pulse start.
  - inst_pc sequence is 0x00,0x02,...,0x30, one per cycle.
  - Word 0x32 is never presented.
  - halted=1 one cycle after the 0x30 pop.
- Backpressure: inst_ready=0 for 5 cycles after start.
  - Buffer holds 0x00 and 0x02; pc stays 0x04.
  - Raising ready releases 0x00, 0x02, 0x04 in order with no gaps.
  - stall_cnt=3 when FETCH_PERF_EN is defined.
- Redirect: while inst_pc=0x16 is valid, assert redirect with redirect_pc=0x1E.
  - Next cycle inst_valid=0.
  - Then inst_pc=0x1E, 0x20, ...
  - Entries 0x16 and 0x18 are never accepted.
- Range exception: redirect_pc=0x34 (word 26).
  - No push; exc=1 once the buffer is empty; exc_pc=0x34.
  - Odd redirect_pc=0x05 gives exc_pc=0x05.
- Redirect during drain: halt word detected with 1 entry buffered, redirect to 0x00 in the same cycle.
  - State returns to RUN; halted stays 0; fetch restarts at 0x00.
- Async reset: drop rst mid-stream between clock edges.
  - inst_valid, halted and exc go to 0 immediately, without waiting for a clock edge.
  - After release and start, fetch resumes from RESET_PC.
